// File: rtl/dpsram_clr_pkg.sv
// Shared types and helpers for the self-clearing dual-port SRAM wrapper.
// Holds the sweep FSM state encoding and the byte-lane mask expander.
package dpsram_clr_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dpsram_clr_state_e;

    // Upper bounds for the lane expander; callers truncate to their own width.
    localparam int unsigned LANE_MAX_NB  = 32'd128;
    localparam int unsigned LANE_MAX_W   = 32'd1024;
    localparam int unsigned LANE_NB_BITS = $clog2(LANE_MAX_NB);
    localparam int unsigned LANE_W_BITS  = $clog2(LANE_MAX_W);

    function automatic logic [LANE_MAX_W-1:0] lane_mask_expand(
        input logic [LANE_MAX_NB-1:0] lanes,
        input int unsigned            byte_size
    );
        logic [LANE_MAX_W-1:0] mask_s;
        int unsigned           lane_s;
        mask_s = {LANE_MAX_W{1'b0}};
        for (int unsigned i = 32'd0; i < LANE_MAX_W; i++) begin
            lane_s = i / byte_size;
            if (lane_s < LANE_MAX_NB) begin
                mask_s[i[LANE_W_BITS-1:0]] = lanes[lane_s[LANE_NB_BITS-1:0]];
            end else begin
                mask_s[i[LANE_W_BITS-1:0]] = 1'b0;
            end
        end
        return mask_s;
    endfunction

endpackage

// File: rtl/dpsram_clr_if.sv
// Access bus of the self-clearing dual-port SRAM: clear request, ready,
// and two independent read/write ports.
interface dpsram_clr_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned BYTE_SIZE  = 8
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_SIZE;
    localparam int unsigned AW = $clog2(DATA_DEPTH);

    logic                  clr_i;
    logic                  ready_o;
    logic                  en0_i;
    logic [NB-1:0]         we0_i;
    logic [AW-1:0]         addr0_i;
    logic [DATA_WIDTH-1:0] wdata0_i;
    logic [DATA_WIDTH-1:0] rdata0_o;
    logic                  valid0_o;
    logic                  en1_i;
    logic [NB-1:0]         we1_i;
    logic [AW-1:0]         addr1_i;
    logic [DATA_WIDTH-1:0] wdata1_i;
    logic [DATA_WIDTH-1:0] rdata1_o;
    logic                  valid1_o;

    modport master (
        output clr_i, en0_i, we0_i, addr0_i, wdata0_i, en1_i, we1_i, addr1_i, wdata1_i,
        input  ready_o, rdata0_o, valid0_o, rdata1_o, valid1_o
    );

    modport slave (
        input  clr_i, en0_i, we0_i, addr0_i, wdata0_i, en1_i, we1_i, addr1_i, wdata1_i,
        output ready_o, rdata0_o, valid0_o, rdata1_o, valid1_o
    );
endinterface

// File: rtl/dpsram.sv
// True dual-port storage primitive with byte-lane writes and registered,
// read-before-write outputs. Used only with a common clock on both ports.
module dpsram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned BYTE_SIZE  = 8,
    localparam int unsigned NB = DATA_WIDTH / BYTE_SIZE,
    localparam int unsigned AW = $clog2(DATA_DEPTH)
) (
    input  logic                  clk0,
    input  logic                  rst_n0,
    input  logic                  en0,
    input  logic [NB-1:0]         we0,
    input  logic [AW-1:0]         addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  clk1,
    input  logic                  rst_n1,
    input  logic                  en1,
    input  logic [NB-1:0]         we1,
    input  logic [AW-1:0]         addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata1
);
    logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rdata0_r;
    logic [DATA_WIDTH-1:0] rdata1_r;

    // Lane writes of both ports; the caller guarantees the lanes never overlap
    always_ff @(posedge clk0) begin
        for (int l = 0; l < NB; l++) begin
            if (en0 && we0[l]) begin
                mem_r[addr0][l*BYTE_SIZE +: BYTE_SIZE] <= wdata0[l*BYTE_SIZE +: BYTE_SIZE];
            end
            if (en1 && we1[l]) begin
                mem_r[addr1][l*BYTE_SIZE +: BYTE_SIZE] <= wdata1[l*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    // Port 0 read register (returns the word as stored before this edge)
    always_ff @(posedge clk0 or negedge rst_n0) begin
        if (!rst_n0) begin
            rdata0_r <= {DATA_WIDTH{1'b0}};
        end else if (en0) begin
            rdata0_r <= mem_r[addr0];
        end
    end

    // Port 1 read register
    always_ff @(posedge clk1 or negedge rst_n1) begin
        if (!rst_n1) begin
            rdata1_r <= {DATA_WIDTH{1'b0}};
        end else if (en1) begin
            rdata1_r <= mem_r[addr1];
        end
    end

    assign rdata0 = rdata0_r;
    assign rdata1 = rdata1_r;
endmodule

// File: rtl/dpsram_clr.sv
// Dual-port SRAM that sweeps itself to INIT_VALUE after reset or on request,
// with write-first reads and port-0-priority same-address collision merging.
module dpsram_clr
    import dpsram_clr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           DATA_DEPTH   = 1024,
    parameter int unsigned           BYTE_SIZE    = 8,
    parameter int unsigned           READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = {DATA_WIDTH{1'b0}}
) (
    input logic         clk,
    input logic         rst_n,
    dpsram_clr_if.slave bus
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_SIZE;
    localparam int unsigned AW = $clog2(DATA_DEPTH);

    dpsram_clr_state_e     state_r, state_s;
    logic [AW-1:0]         cnt_r, cnt_s;
    logic                  ready_s, acc0_s, acc1_s, cross_s;
    logic [NB-1:0]         we0_eff_s, we1_eff_s, mask0_s, mask1_s, sel1_s;
    logic [DATA_WIDTH-1:0] sel0_wide_s, sel1_wide_s, data0_s, data1_s;
    logic                  mem_en0_s, mem_en1_s;
    logic [NB-1:0]         mem_we0_s, mem_we1_s;
    logic [AW-1:0]         mem_addr0_s, mem_addr1_s;
    logic [DATA_WIDTH-1:0] mem_wdata0_s, mem_wdata1_s, mem_rdata0_s, mem_rdata1_s;
    logic                  valid0_r, valid1_r;
    logic [NB-1:0]         mask0_r, mask1_r;
    logic [DATA_WIDTH-1:0] wdat0_r, wdat1_r, mask0_wide_s, mask1_wide_s, merged0_s, merged1_s;

    assign ready_s     = (state_r == IDLE);
    assign bus.ready_o = ready_s;

    // Sweep FSM state and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CLEAR;
            cnt_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Sweep next state: two entries per cycle, restart on any clear request
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            CLEAR: begin
                if (bus.clr_i) begin
                    cnt_s = {AW{1'b0}};
                end else if (cnt_r == AW'(DATA_DEPTH - 32'd2)) begin
                    state_s = IDLE;
                    cnt_s   = {AW{1'b0}};
                end else begin
                    cnt_s = cnt_r + AW'(32'd2);
                end
            end
            IDLE: begin
                if (bus.clr_i) begin
                    state_s = CLEAR;
                    cnt_s   = {AW{1'b0}};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = CLEAR;
                cnt_s   = {AW{1'b0}};
            end
        endcase
    end

    // Acceptance and collision resolution; port 0 owns every lane it writes
    always_comb begin
        acc0_s  = ready_s & ~bus.clr_i & bus.en0_i;
        acc1_s  = ready_s & ~bus.clr_i & bus.en1_i;
        cross_s = acc0_s & acc1_s & (bus.addr0_i == bus.addr1_i);
        if (acc0_s) begin
            we0_eff_s = bus.we0_i;
        end else begin
            we0_eff_s = {NB{1'b0}};
        end
        if (acc1_s && cross_s) begin
            we1_eff_s = bus.we1_i & ~we0_eff_s;
        end else if (acc1_s) begin
            we1_eff_s = bus.we1_i;
        end else begin
            we1_eff_s = {NB{1'b0}};
        end
        if (cross_s) begin
            mask0_s = we0_eff_s | we1_eff_s;
            mask1_s = we0_eff_s | we1_eff_s;
            sel1_s  = we0_eff_s;
        end else begin
            mask0_s = we0_eff_s;
            mask1_s = we1_eff_s;
            sel1_s  = {NB{1'b0}};
        end
    end

    assign sel0_wide_s = DATA_WIDTH'(lane_mask_expand(LANE_MAX_NB'(we0_eff_s), BYTE_SIZE));
    assign sel1_wide_s = DATA_WIDTH'(lane_mask_expand(LANE_MAX_NB'(sel1_s), BYTE_SIZE));
    assign data0_s     = (bus.wdata0_i & sel0_wide_s) | (bus.wdata1_i & ~sel0_wide_s);
    assign data1_s     = (bus.wdata0_i & sel1_wide_s) | (bus.wdata1_i & ~sel1_wide_s);

    // Storage port muxes: sweep owns both ports while clearing
    always_comb begin
        if (state_r == CLEAR) begin
            mem_en0_s    = 1'b1;
            mem_en1_s    = 1'b1;
            mem_we0_s    = {NB{1'b1}};
            mem_we1_s    = {NB{1'b1}};
            mem_addr0_s  = cnt_r;
            mem_addr1_s  = cnt_r | AW'(32'd1);
            mem_wdata0_s = INIT_VALUE;
            mem_wdata1_s = INIT_VALUE;
        end else begin
            mem_en0_s    = acc0_s;
            mem_en1_s    = acc1_s;
            mem_we0_s    = we0_eff_s;
            mem_we1_s    = we1_eff_s;
            mem_addr0_s  = bus.addr0_i;
            mem_addr1_s  = bus.addr1_i;
            mem_wdata0_s = bus.wdata0_i;
            mem_wdata1_s = bus.wdata1_i;
        end
    end

    dpsram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .BYTE_SIZE  (BYTE_SIZE)
    ) u_mem (
        .clk0   (clk),
        .rst_n0 (rst_n),
        .en0    (mem_en0_s),
        .we0    (mem_we0_s),
        .addr0  (mem_addr0_s),
        .wdata0 (mem_wdata0_s),
        .rdata0 (mem_rdata0_s),
        .clk1   (clk),
        .rst_n1 (rst_n),
        .en1    (mem_en1_s),
        .we1    (mem_we1_s),
        .addr1  (mem_addr1_s),
        .wdata1 (mem_wdata1_s),
        .rdata1 (mem_rdata1_s)
    );

    // Lane mask and merged write data travel alongside the primitive read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            mask0_r  <= {NB{1'b0}};
            mask1_r  <= {NB{1'b0}};
            wdat0_r  <= {DATA_WIDTH{1'b0}};
            wdat1_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            valid0_r <= acc0_s;
            valid1_r <= acc1_s;
            if (acc0_s) begin
                mask0_r <= mask0_s;
                wdat0_r <= data0_s;
            end
            if (acc1_s) begin
                mask1_r <= mask1_s;
                wdat1_r <= data1_s;
            end
        end
    end

    assign mask0_wide_s = DATA_WIDTH'(lane_mask_expand(LANE_MAX_NB'(mask0_r), BYTE_SIZE));
    assign mask1_wide_s = DATA_WIDTH'(lane_mask_expand(LANE_MAX_NB'(mask1_r), BYTE_SIZE));
    assign merged0_s    = (mem_rdata0_s & ~mask0_wide_s) | (wdat0_r & mask0_wide_s);
    assign merged1_s    = (mem_rdata1_s & ~mask1_wide_s) | (wdat1_r & mask1_wide_s);

    generate
        if (READ_LATENCY == 32'd2) begin : g_lat2
            logic                  out_valid0_r, out_valid1_r;
            logic [DATA_WIDTH-1:0] out_rdata0_r, out_rdata1_r;

            // Extra output stage; data only moves on a valid beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid0_r <= 1'b0;
                    out_valid1_r <= 1'b0;
                    out_rdata0_r <= {DATA_WIDTH{1'b0}};
                    out_rdata1_r <= {DATA_WIDTH{1'b0}};
                end else begin
                    out_valid0_r <= valid0_r;
                    out_valid1_r <= valid1_r;
                    if (valid0_r) out_rdata0_r <= merged0_s;
                    if (valid1_r) out_rdata1_r <= merged1_s;
                end
            end

            assign bus.valid0_o = out_valid0_r;
            assign bus.valid1_o = out_valid1_r;
            assign bus.rdata0_o = out_rdata0_r;
            assign bus.rdata1_o = out_rdata1_r;
        end else begin : g_lat1
            logic [DATA_WIDTH-1:0] hold0_r, hold1_r;

            // Last delivered word, shown while no beat is valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold0_r <= {DATA_WIDTH{1'b0}};
                    hold1_r <= {DATA_WIDTH{1'b0}};
                end else begin
                    if (valid0_r) hold0_r <= merged0_s;
                    if (valid1_r) hold1_r <= merged1_s;
                end
            end

            assign bus.valid0_o = valid0_r;
            assign bus.valid1_o = valid1_r;
            assign bus.rdata0_o = valid0_r ? merged0_s : hold0_r;
            assign bus.rdata1_o = valid1_r ? merged1_s : hold1_r;
        end
    endgenerate
endmodule
